// File: rtl/serial_subtract_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and default width.
// The optional overflow output is enabled by defining SERIAL_SUB_OVF_EN.
package serial_subtract_ctrl_pkg;

    localparam int SUB_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtract_ctrl_bit_sub.sv
// One-bit full subtractor cell: d = a - b - bi, with borrow-out bo.
module bit_sub (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtract_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller: diff = a - b - borrow_in, LSB first through one bit_sub cell.
// Define SERIAL_SUB_OVF_EN to add the registered two's-complement overflow output.
module serial_subtract_ctrl
    import serial_subtract_ctrl_pkg::*;
#(
    parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sr, b_sr, r_sr;
    logic             brw;
    logic [CW-1:0]    count;
    logic             cell_d, cell_bo;
    logic             load, last;

    bit_sub u_cell (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .bi (brw),
        .d  (cell_d),
        .bo (cell_bo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        last       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (count == LAST) begin
                    last       = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Results are committed only on the last bit, so diff/borrow_out never expose partial sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr       <= '0;
            b_sr       <= '0;
            r_sr       <= '0;
            brw        <= 1'b0;
            count      <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            overflow   <= 1'b0;
`endif
        end else begin
            if (load) begin
                a_sr  <= a;
                b_sr  <= b;
                brw   <= borrow_in;
                count <= '0;
            end
            if (state == ST_SHIFT) begin
                r_sr  <= {cell_d, r_sr[WIDTH-1:1]};
                a_sr  <= a_sr >> 1;
                b_sr  <= b_sr >> 1;
                brw   <= cell_bo;
                count <= count + 1'b1;
                if (last) begin
                    diff       <= {cell_d, r_sr[WIDTH-1:1]};
                    borrow_out <= cell_bo;
`ifdef SERIAL_SUB_OVF_EN
                    // brw here is the borrow into the MSB
                    overflow   <= brw ^ cell_bo;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// Scoreboard bench for serial_subtract_ctrl (WIDTH=8); overflow is checked when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtract_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         borrow_in = 1'b0;
    logic         busy, done, borrow_out;
    logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
    logic         overflow;
`endif

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   failed = 0;
    int   cyc;

    serial_subtract_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .overflow   (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        exp_t        e;
        logic [W:0]  full;
        int          s;
        full  = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
        e.d   = full[W-1:0];
        e.bo  = full[W];
        s     = int'($signed(x)) - int'($signed(y)) - int'(bi);
        e.ovf = (s > 127) || (s < -128);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("diff", diff, mon_e.d);
                checkOutput("borrow_out", borrow_out, mon_e.bo);
`ifdef SERIAL_SUB_OVF_EN
                checkOutput("overflow", overflow, mon_e.ovf);
`endif
            end
        end
    end

    // Drives one request from an IDLE cycle; returns just after the accepting edge.
    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (busy) checkOutput("idle_timeout", 1, 0);
        a = x; b = y; borrow_in = bi; start = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(x, y, bi));
        #1 start = 1'b0;
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1 cycles++;
        end while (!done && cycles < 30);
        if (!done) checkOutput("done_timeout", 0, 1);
    endtask

    initial begin
        #12;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_diff", diff, 0);
        checkOutput("reset_borrow", borrow_out, 0);
        @(negedge clk) rst_n = 1'b1;

        // Directed vectors; the accepting cycle counts as cycle 1, so done lands in cycle W+1
        applyStimulus(8'h05, 8'h03, 1'b0);
        checkOutput("busy_shift", busy, 1);
        waitDone(cyc);
        checkOutput("done_cycle", cyc + 1, W + 1);
        applyStimulus(8'h03, 8'h05, 1'b0); waitDone(cyc);
        applyStimulus(8'h00, 8'h00, 1'b1); waitDone(cyc);
        applyStimulus(8'h80, 8'h01, 1'b0); waitDone(cyc);
        applyStimulus(8'h10, 8'h01, 1'b0); waitDone(cyc);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom));
            waitDone(cyc);
        end

        // A start pulse during SHIFT must be dropped
        applyStimulus(8'h03, 8'h05, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        a = 8'hFF; b = 8'h00; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitDone(cyc);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("held_diff", diff, 8'hFE);
        checkOutput("no_extra_busy", busy, 0);

        // Reset in the fourth SHIFT cycle aborts with no done pulse
        applyStimulus(8'h55, 8'h22, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_diff", diff, 0);
        checkOutput("abort_borrow", borrow_out, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1 checkOutput("abort_idle", busy, 0);

        // start held high: second result follows the first by W+2 cycles
        @(negedge clk);
        a = 8'h20; b = 8'h30; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(8'h20, 8'h30, 1'b0));
        #1 a = 8'h44; b = 8'h11; borrow_in = 1'b1;
        exp_q.push_back(model(8'h44, 8'h11, 1'b1));
        waitDone(cyc);
        waitDone(cyc);
        start = 1'b0;
        checkOutput("b2b_interval", cyc, W + 2);
        repeat (15) @(posedge clk);
        #1 checkOutput("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
